// File: rtl/gpu_mem_pkg.sv
// Shared types for the data-memory controller.
// Channel FSM encodings and index-width helper.
package gpu_mem_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_WAIT  = 3'd1;
  localparam logic [2:0] ST_WR_WAIT  = 3'd2;
  localparam logic [2:0] ST_RD_RELAY = 3'd3;
  localparam logic [2:0] ST_WR_RELAY = 3'd4;

  typedef enum logic [2:0] {
    CH_IDLE     = ST_IDLE,
    CH_RD_WAIT  = ST_RD_WAIT,
    CH_WR_WAIT  = ST_WR_WAIT,
    CH_RD_RELAY = ST_RD_RELAY,
    CH_WR_RELAY = ST_WR_RELAY
  } mem_chan_state_t;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_mem_controller_channel.sv
// One memory channel: FSM, owner index and captured request.
// Consumer-side readiness is decoded directly from the state.
module mem_channel
  import gpu_mem_pkg::*;
#(
  parameter int IDX_W     = 3,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 grant_i,
  input  logic                 grant_wr_i,
  input  logic [IDX_W-1:0]     grant_idx_i,
  input  logic [ADDR_BITS-1:0] grant_addr_i,
  input  logic [DATA_BITS-1:0] grant_data_i,
  input  logic                 owner_rd_valid_i,
  input  logic                 owner_wr_valid_i,
  input  logic                 mem_rd_ready_i,
  input  logic [DATA_BITS-1:0] mem_rd_data_i,
  input  logic                 mem_wr_ready_i,
  output logic                 idle_o,
  output logic                 release_o,
  output logic [IDX_W-1:0]     owner_o,
  output logic                 mem_rd_valid_o,
  output logic                 mem_wr_valid_o,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic [DATA_BITS-1:0] wdata_o,
  output logic                 rd_ready_o,
  output logic                 wr_ready_o,
  output logic [DATA_BITS-1:0] rdata_o
);

  mem_chan_state_t      state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CH_IDLE;
      owner_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    release_o = 1'b0;
    unique case (state_q)
      CH_IDLE: begin
        if (grant_i) begin
          owner_d = grant_idx_i;
          addr_d  = grant_addr_i;
          wdata_d = grant_data_i;
          state_d = grant_wr_i ? CH_WR_WAIT : CH_RD_WAIT;
        end
      end
      CH_RD_WAIT: begin
        if (mem_rd_ready_i) begin
          rdata_d = mem_rd_data_i;
          state_d = CH_RD_RELAY;
        end
      end
      CH_WR_WAIT: begin
        if (mem_wr_ready_i) state_d = CH_WR_RELAY;
      end
      CH_RD_RELAY: begin
        if (!owner_rd_valid_i) begin
          release_o = 1'b1;
          state_d   = CH_IDLE;
        end
      end
      CH_WR_RELAY: begin
        if (!owner_wr_valid_i) begin
          release_o = 1'b1;
          state_d   = CH_IDLE;
        end
      end
      default: state_d = CH_IDLE;
    endcase
  end

  assign idle_o         = (state_q == CH_IDLE);
  assign owner_o        = owner_q;
  assign mem_rd_valid_o = (state_q == CH_RD_WAIT);
  assign mem_wr_valid_o = (state_q == CH_WR_WAIT);
  assign addr_o         = addr_q;
  assign wdata_o        = wdata_q;
  assign rd_ready_o     = (state_q == CH_RD_RELAY);
  assign wr_ready_o     = (state_q == CH_WR_RELAY);
  assign rdata_o        = rdata_q;

endmodule

// File: rtl/data_mem_controller.sv
// Round-robin arbiter of consumer LSU requests onto memory channels.
// Holds rr pointer and serving mask; channels hold the transactions.
module data_mem_controller
  import gpu_mem_pkg::*;
#(
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 2,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

  localparam int NC    = NUM_CONSUMERS;
  localparam int NCH   = NUM_CHANNELS;
  localparam int IDX_W = idx_bits(NC);
  localparam bit WE    = (WRITE_ENABLE != 0);

  logic [IDX_W-1:0] rr_q, rr_d;
  logic [NC-1:0]    serving_q, serving_d;
  logic [NC-1:0]    taken, rel_mask, req_rd, req_wr;
  logic             found;
  int               scan_s;

  logic [NCH-1:0]                ch_idle, ch_release;
  logic [NCH-1:0]                ch_rd_valid, ch_wr_valid;
  logic [NCH-1:0]                ch_rd_ready, ch_wr_ready;
  logic [NCH-1:0]                own_rv, own_wv;
  logic [NCH-1:0]                grant, grant_wr;
  logic [NCH-1:0][IDX_W-1:0]     ch_owner, grant_idx;
  logic [NCH-1:0][ADDR_BITS-1:0] ch_addr, grant_addr;
  logic [NCH-1:0][DATA_BITS-1:0] ch_wdata, ch_rdata, grant_data;

  assign req_rd = consumer_read_valid;
  assign req_wr = WE ? consumer_write_valid : '0;

  // Idle channels claim, in ascending order, the next free requester from rr_q.
  always_comb begin
    taken      = serving_q;
    rr_d       = rr_q;
    grant      = '0;
    grant_wr   = '0;
    grant_idx  = '0;
    grant_addr = '0;
    grant_data = '0;
    found      = 1'b0;
    scan_s     = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      found = 1'b0;
      if (ch_idle[ch]) begin
        for (int k = 0; k < NC; k++) begin
          scan_s = int'(rr_q) + k;
          if (scan_s >= NC) scan_s = scan_s - NC;
          if (!found && (req_rd[scan_s] || req_wr[scan_s])
              && !taken[scan_s]) begin
            found          = 1'b1;
            taken[scan_s]  = 1'b1;
            grant[ch]      = 1'b1;
            grant_wr[ch]   = !req_rd[scan_s];
            grant_idx[ch]  = IDX_W'(scan_s);
            grant_addr[ch] = req_rd[scan_s]
                           ? consumer_read_address[scan_s]
                           : consumer_write_address[scan_s];
            grant_data[ch] = consumer_write_data[scan_s];
            rr_d = (scan_s == NC - 1) ? '0 : IDX_W'(scan_s + 1);
          end
        end
      end
    end
  end

  always_comb begin
    own_rv = '0;
    own_wv = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      own_rv[ch] = consumer_read_valid[ch_owner[ch]];
      own_wv[ch] = consumer_write_valid[ch_owner[ch]];
    end
  end

  always_comb begin
    consumer_read_ready  = '0;
    consumer_read_data   = '0;
    consumer_write_ready = '0;
    rel_mask             = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (ch_rd_ready[ch]) begin
        consumer_read_ready[ch_owner[ch]] = 1'b1;
        consumer_read_data[ch_owner[ch]]  = ch_rdata[ch];
      end
      if (WE && ch_wr_ready[ch])
        consumer_write_ready[ch_owner[ch]] = 1'b1;
      if (ch_release[ch]) rel_mask[ch_owner[ch]] = 1'b1;
    end
  end

  assign serving_d = taken & ~rel_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q      <= '0;
      serving_q <= '0;
    end else begin
      rr_q      <= rr_d;
      serving_q <= serving_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    mem_channel #(
      .IDX_W    (IDX_W),
      .ADDR_BITS(ADDR_BITS),
      .DATA_BITS(DATA_BITS)
    ) u_ch (
      .clk             (clk),
      .reset           (reset),
      .grant_i         (grant[g]),
      .grant_wr_i      (grant_wr[g]),
      .grant_idx_i     (grant_idx[g]),
      .grant_addr_i    (grant_addr[g]),
      .grant_data_i    (grant_data[g]),
      .owner_rd_valid_i(own_rv[g]),
      .owner_wr_valid_i(own_wv[g]),
      .mem_rd_ready_i  (mem_read_ready[g]),
      .mem_rd_data_i   (mem_read_data[g]),
      .mem_wr_ready_i  (mem_write_ready[g]),
      .idle_o          (ch_idle[g]),
      .release_o       (ch_release[g]),
      .owner_o         (ch_owner[g]),
      .mem_rd_valid_o  (ch_rd_valid[g]),
      .mem_wr_valid_o  (ch_wr_valid[g]),
      .addr_o          (ch_addr[g]),
      .wdata_o         (ch_wdata[g]),
      .rd_ready_o      (ch_rd_ready[g]),
      .wr_ready_o      (ch_wr_ready[g]),
      .rdata_o         (ch_rdata[g])
    );

    assign mem_read_valid[g]    = ch_rd_valid[g];
    assign mem_read_address[g]  = ch_addr[g];
    assign mem_write_valid[g]   = WE ? ch_wr_valid[g] : 1'b0;
    assign mem_write_address[g] = WE ? ch_addr[g] : '0;
    assign mem_write_data[g]    = WE ? ch_wdata[g] : '0;
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench for data_mem_controller.
// Covers read, write, contention, fairness, reset and read-only.
module tb_data_mem_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0]      rv, wv, crr, cwr;
  logic [7:0][7:0] ra, wa, wd, crd;
  logic [1:0]      mrv, mwv, mrr, mwr;
  logic [1:0][7:0] mra, mwa, mwd, mrd;
  logic            auto_mem;
  logic [1:0]      man_mrr, man_mwr;
  logic [1:0][7:0] man_mrd;

  logic [7:0]      ro_rv, ro_wv, ro_crr, ro_cwr;
  logic [7:0][7:0] ro_ra, ro_wa, ro_wd, ro_crd;
  logic [1:0]      ro_mrv, ro_mwv, ro_mrr, ro_mwr;
  logic [1:0][7:0] ro_mra, ro_mwa, ro_mwd, ro_mrd;

  // Auto memory answers a read in the cycle it is requested: data = addr ^ C3.
  always_comb begin
    mrr = auto_mem ? mrv : man_mrr;
    ro_mrr = ro_mrv;
    for (int c = 0; c < 2; c++) begin
      mrd[c] = auto_mem ? (mra[c] ^ 8'hC3) : man_mrd[c];
      ro_mrd[c] = ro_mra[c] ^ 8'hC3;
    end
  end
  assign mwr = man_mwr;

  data_mem_controller dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(ra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(wv), .consumer_write_address(wa),
    .consumer_write_data(wd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr)
  );

  data_mem_controller #(.WRITE_ENABLE(0)) dut_ro (
    .clk(clk), .reset(reset),
    .consumer_read_valid(ro_rv), .consumer_read_address(ro_ra),
    .consumer_read_ready(ro_crr), .consumer_read_data(ro_crd),
    .consumer_write_valid(ro_wv), .consumer_write_address(ro_wa),
    .consumer_write_data(ro_wd), .consumer_write_ready(ro_cwr),
    .mem_read_valid(ro_mrv), .mem_read_address(ro_mra),
    .mem_read_ready(ro_mrr), .mem_read_data(ro_mrd),
    .mem_write_valid(ro_mwv), .mem_write_address(ro_mwa),
    .mem_write_data(ro_mwd), .mem_write_ready(ro_mwr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if ({crr, cwr, mrv, mwv} !== '0) begin
      bad++;
      $display("FAIL reset_valids got=%h want=0", {crr, cwr, mrv, mwv});
    end
    total++;
    if ({mra, mwa, mwd, crd} !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0", {mra, mwa, mwd, crd});
    end
    reset = 1'b0;
  endtask

  task automatic test_read();
    auto_mem = 1'b0;
    rv[3] = 1'b1;
    ra[3] = 8'h10;
    tick();
    total++;
    if (mrv !== 2'b01 || mra[0] !== 8'h10) begin
      bad++;
      $display("FAIL read_grant got=%b/%h want=01/10", mrv, mra[0]);
    end
    total++;
    if (crr !== 8'h00) begin
      bad++;
      $display("FAIL read_early_ready got=%h want=00", crr);
    end
    man_mrr = 2'b01;
    man_mrd[0] = 8'hAB;
    tick();
    man_mrr = 2'b00;
    total++;
    if (crr !== 8'h08 || crd[3] !== 8'hAB || mrv !== 2'b00) begin
      bad++;
      $display("FAIL read_ready got=%h/%h/%b want=08/ab/00",
               crr, crd[3], mrv);
    end
    tick();
    total++;
    if (crr !== 8'h08) begin
      bad++;
      $display("FAIL read_hold got=%h want=08", crr);
    end
    rv[3] = 1'b0;
    tick();
    total++;
    if (crr !== 8'h00 || mrv !== 2'b00) begin
      bad++;
      $display("FAIL read_release got=%h/%b want=00/00", crr, mrv);
    end
  endtask

  task automatic test_write();
    wv[2] = 1'b1;
    wa[2] = 8'h20;
    wd[2] = 8'h5A;
    tick();
    total++;
    if (mwv !== 2'b01 || mrv !== 2'b00
        || mwa[0] !== 8'h20 || mwd[0] !== 8'h5A) begin
      bad++;
      $display("FAIL write_grant got=%b/%b/%h/%h want=01/00/20/5a",
               mwv, mrv, mwa[0], mwd[0]);
    end
    wa[2] = 8'hFF;
    wd[2] = 8'h00;
    tick();
    total++;
    if (mwa[0] !== 8'h20 || mwd[0] !== 8'h5A || cwr !== 8'h00) begin
      bad++;
      $display("FAIL write_capture got=%h/%h/%h want=20/5a/00",
               mwa[0], mwd[0], cwr);
    end
    man_mwr = 2'b01;
    tick();
    man_mwr = 2'b00;
    total++;
    if (cwr !== 8'h04 || mwv !== 2'b00) begin
      bad++;
      $display("FAIL write_ready got=%h/%b want=04/00", cwr, mwv);
    end
    tick();
    total++;
    if (cwr !== 8'h04) begin
      bad++;
      $display("FAIL write_hold got=%h want=04", cwr);
    end
    wv[2] = 1'b0;
    tick();
    total++;
    if (cwr !== 8'h00) begin
      bad++;
      $display("FAIL write_release got=%h want=00", cwr);
    end
  endtask

  task automatic test_reset_midop();
    rv[5] = 1'b1;
    ra[5] = 8'h33;
    tick();
    total++;
    if (mrv !== 2'b01 || mra[0] !== 8'h33) begin
      bad++;
      $display("FAIL midop_grant got=%b/%h want=01/33", mrv, mra[0]);
    end
    reset = 1'b1;
    man_mrr = 2'b01;
    man_mrd[0] = 8'h99;
    #1;
    total++;
    if ({mrv, mwv, crr, cwr} !== '0 || {mra, crd} !== '0) begin
      bad++;
      $display("FAIL midop_async got=%h/%h want=0",
               {mrv, mwv, crr, cwr}, {mra, crd});
    end
    tick();
    reset = 1'b0;
    rv[5] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (crr !== 8'h00 || mrv !== 2'b00) begin
        bad++;
        $display("FAIL midop_after got=%h/%b want=00/00", crr, mrv);
      end
    end
    man_mrr = 2'b00;
  endtask

  task automatic test_contention();
    logic [3:0] done;
    do_reset();
    auto_mem = 1'b1;
    for (int i = 0; i < 4; i++) ra[i] = 8'(8'h40 + i);
    rv = 8'h0F;
    tick();
    total++;
    if (mrv !== 2'b11 || mra[0] !== 8'h40 || mra[1] !== 8'h41) begin
      bad++;
      $display("FAIL cont_first got=%b/%h/%h want=11/40/41",
               mrv, mra[0], mra[1]);
    end
    done = '0;
    for (int cyc = 0; cyc < 40 && done != 4'hF; cyc++) begin
      tick();
      if (mrv == 2'b11) begin
        total++;
        if (mra[0] === mra[1]) begin
          bad++;
          $display("FAIL cont_double got=%h/%h want=distinct",
                   mra[0], mra[1]);
        end
      end
      total++;
      if ((crr & 8'hF0) !== 8'h00) begin
        bad++;
        $display("FAIL cont_stray got=%h want=0x", crr);
      end
      for (int i = 0; i < 4; i++) begin
        if (crr[i] && rv[i]) begin
          total++;
          if (crd[i] !== 8'((8'h40 + i) ^ 8'hC3)) begin
            bad++;
            $display("FAIL cont_data c%0d got=%h want=%h",
                     i, crd[i], 8'((8'h40 + i) ^ 8'hC3));
          end
          done[i] = 1'b1;
          rv[i] = 1'b0;
        end
      end
    end
    total++;
    if (done !== 4'hF) begin
      bad++;
      $display("FAIL cont_all got=%b want=1111", done);
    end
    rv = '0;
    tick();
  endtask

  task automatic test_fairness();
    logic got7;
    int at7, hogs;
    do_reset();
    auto_mem = 1'b1;
    for (int i = 0; i < 4; i++) ra[i] = 8'(8'h50 + i);
    ra[7] = 8'h77;
    rv = 8'h8F;
    got7 = 1'b0;
    at7 = -1;
    hogs = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (crr[i] && rv[i]) begin
          hogs++;
          rv[i] = 1'b0;
        end else if (!crr[i]) begin
          rv[i] = 1'b1;
        end
      end
      if (crr[7] && rv[7]) begin
        got7 = 1'b1;
        at7 = cyc;
        total++;
        if (crd[7] !== 8'hB4) begin
          bad++;
          $display("FAIL fair_data got=%h want=b4", crd[7]);
        end
        rv[7] = 1'b0;
      end
    end
    total++;
    if (!got7 || at7 > 16) begin
      bad++;
      $display("FAIL fair_c7 got=%0b@%0d want=1@<=16", got7, at7);
    end
    total++;
    if (hogs < 20) begin
      bad++;
      $display("FAIL fair_hogs got=%0d want>=20", hogs);
    end
    rv = '0;
    for (int i = 0; i < 4; i++) tick();
    auto_mem = 1'b0;
  endtask

  task automatic test_write_disabled();
    logic got;
    got = 1'b0;
    ro_mwr = 2'b11;
    ro_wv[1] = 1'b1;
    ro_wa[1] = 8'h11;
    ro_wd[1] = 8'h22;
    ro_rv[4] = 1'b1;
    ro_ra[4] = 8'h44;
    tick();
    total++;
    if (ro_mrv !== 2'b01 || ro_mra[0] !== 8'h44) begin
      bad++;
      $display("FAIL ro_read_grant got=%b/%h want=01/44",
               ro_mrv, ro_mra[0]);
    end
    for (int cyc = 0; cyc < 10; cyc++) begin
      total++;
      if (ro_mwv !== 2'b00 || ro_cwr !== 8'h00
          || {ro_mwa, ro_mwd} !== '0) begin
        bad++;
        $display("FAIL ro_write got=%b/%h/%h want=0",
                 ro_mwv, ro_cwr, {ro_mwa, ro_mwd});
      end
      if (ro_crr[4] && ro_rv[4]) begin
        got = 1'b1;
        total++;
        if (ro_crd[4] !== 8'h87) begin
          bad++;
          $display("FAIL ro_read_data got=%h want=87", ro_crd[4]);
        end
        ro_rv[4] = 1'b0;
      end
      tick();
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL ro_read_done got=0 want=1");
    end
    ro_wv = '0;
  endtask

  initial begin
    rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
    ro_rv = '0; ro_wv = '0; ro_ra = '0; ro_wa = '0; ro_wd = '0;
    ro_mwr = '0;
    auto_mem = 1'b0;
    man_mrr = '0;
    man_mwr = '0;
    man_mrd = '0;
    test_reset();
    test_read();
    test_write();
    test_reset_midop();
    test_contention();
    test_fairness();
    test_write_disabled();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
